// File: rtl/bus_dev_fifo.sv
// Device-side bus endpoint: FWFT transmit FIFO toward the bus and a destination-filtered receive capture.
// Optional macro BUS_DEV_FIFO_RX_FILTER_EN enables the RX destination filter; undefined accepts every push.
module bus_dev_fifo #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  dev_id    = 8'h00,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_push,
  input  logic [pckg_sz-1:0]     tx_data,
  output logic                   tx_full,
  output logic                   pndng,
  output logic [pckg_sz-1:0]     D_pop,
  input  logic                   pop,
  input  logic                   push,
  input  logic [pckg_sz-1:0]     D_push,
  output logic                   rx_valid,
  output logic [pckg_sz-1:0]     rx_data,
  output logic [$clog2(depth):0] tx_count,
  output logic                   ovf,
  output logic                   udf
);

  localparam int            AW       = $clog2(depth);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(depth);

`ifdef BUS_DEV_FIFO_RX_FILTER_EN
  localparam bit RX_FILTER = 1'b1;
`else
  localparam bit RX_FILTER = 1'b0;
`endif

  logic [pckg_sz-1:0] r_mem [depth];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_count;
  logic               r_ovf;
  logic               r_udf;
  logic               r_rx_valid;
  logic [pckg_sz-1:0] r_rx_data;

  logic               w_empty;
  logic               w_full;
  logic               w_do_pop;
  logic               w_do_push;
  logic [7:0]         w_dest;
  logic               w_dest_match;
  logic               w_rx_accept;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  // At full, a simultaneous pop frees the slot the write lands in.
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = tx_push && (!w_full || w_do_pop);

  assign w_dest       = D_push[pckg_sz-1 -: 8];
  assign w_dest_match = (w_dest == dev_id) || (w_dest == broadcast);
  assign w_rx_accept  = push && (!RX_FILTER || w_dest_match);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (tx_push && !w_do_push) r_ovf <= 1'b1;
      if (pop && w_empty)        r_udf <= 1'b1;
    end
  end

  // NOTE: storage has no reset; its contents are never observed while the
  // FIFO is empty, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_valid <= w_rx_accept;
      if (w_rx_accept) r_rx_data <= D_push;
    end
  end

  // Head is masked while empty so D_pop reads zero out of reset.
  assign D_pop    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign pndng    = !w_empty;
  assign tx_full  = w_full;
  assign tx_count = r_count;
  assign ovf      = r_ovf;
  assign udf      = r_udf;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Self-checking bench for bus_dev_fifo: directed plan steps plus random traffic against a queue model.
module tb_bus_dev_fifo;

  localparam int         W     = 16;
  localparam int         DEPTH = 8;
  localparam logic [7:0] DEV   = 8'h02;
  localparam logic [7:0] BCAST = 8'hFF;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_push = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_full;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         pop = 1'b0;
  logic         push = 1'b0;
  logic [W-1:0] D_push = '0;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic [3:0]   tx_count;
  logic         ovf;
  logic         udf;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] m_q[$];
  bit           m_ovf, m_udf, m_rxv;
  logic [W-1:0] m_rxd;

  bus_dev_fifo #(.pckg_sz(W), .depth(DEPTH), .dev_id(DEV), .broadcast(BCAST)) dut (
    .clk(clk), .reset(reset), .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_count(tx_count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit accepts(input logic [W-1:0] pkt);
`ifdef BUS_DEV_FIFO_RX_FILTER_EN
    return (pkt[W-1 -: 8] == DEV) || (pkt[W-1 -: 8] == BCAST);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_model();
    check("tx_count", tx_count, m_q.size());
    check("pndng", pndng, m_q.size() != 0);
    check("tx_full", tx_full, m_q.size() == DEPTH);
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
    check("rx_valid", rx_valid, m_rxv);
    check("rx_data", rx_data, m_rxd);
    if (m_q.size() != 0) check("D_pop", D_pop, m_q[0]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rxv = 1'b0; m_rxd = '0;
  endtask

  // One clock cycle of stimulus; model advances by the FIFO's occupancy rules.
  task automatic step(input bit p, input logic [W-1:0] d, input bit q,
                      input bit rp, input logic [W-1:0] rd);
    int c;
    bit dp, dw;
    tx_push = p; tx_data = d; pop = q; push = rp; D_push = rd;
    @(posedge clk);
    #1;
    c  = m_q.size();
    dp = q && (c > 0);
    dw = p && ((c < DEPTH) || dp);
    if (q && c == 0) m_udf = 1'b1;
    if (p && !dw)    m_ovf = 1'b1;
    if (dp) void'(m_q.pop_front());
    if (dw) m_q.push_back(d);
    m_rxv = rp && accepts(rd);
    if (m_rxv) m_rxd = rd;
    tx_push = 1'b0; pop = 1'b0; push = 1'b0;
    check_model();
  endtask

  initial begin
    do_reset();
    check("rst_pndng", pndng, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_tx_count", tx_count, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_D_pop", D_pop, 0);

    // Single write then read
    step(1, 16'h0312, 0, 0, '0);
    check("single_D_pop", D_pop, 16'h0312);
    check("single_count", tx_count, 1);
    step(0, '0, 1, 0, '0);
    check("single_empty", pndng, 0);

    // Fill, then simultaneous push+pop at full
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i), 0, 0, '0);
    check("fill_full", tx_full, 1);
    check("fill_count", tx_count, 8);
    step(1, 16'h0108, 1, 0, '0);
    check("fullpp_count", tx_count, 8);
    check("fullpp_D_pop", D_pop, 16'h0101);
    check("fullpp_ovf", ovf, 0);

    // Reset mid-stream discards everything
    do_reset();
    check("midrst_count", tx_count, 0);
    check("midrst_pndng", pndng, 0);

    // Overflow and wrap ordering
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i), 0, 0, '0);
    step(1, 16'h01FF, 0, 0, '0);
    check("ovf_set", ovf, 1);
    check("ovf_head", D_pop, 16'h0100);
    check("ovf_count", tx_count, 8);
    repeat (3) step(0, '0, 1, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 16'h0108 + 16'(i), 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      check("wrap_order", D_pop, 16'h0103 + 16'(i));
      step(0, '0, 1, 0, '0);
    end
    check("wrap_drained", pndng, 0);

    // Underflow leaves pointers intact
    step(0, '0, 1, 0, '0);
    check("udf_set", udf, 1);
    check("udf_count", tx_count, 0);
    step(1, 16'h0555, 0, 0, '0);
    check("udf_recover", D_pop, 16'h0555);
    step(0, '0, 1, 0, '0);

    // Receive path, back-to-back pushes
    step(0, '0, 0, 1, 16'h02AB);
    check("rx_own_valid", rx_valid, 1);
    check("rx_own_data", rx_data, 16'h02AB);
    step(0, '0, 0, 1, 16'h03CD);
`ifdef BUS_DEV_FIFO_RX_FILTER_EN
    check("rx_other_valid", rx_valid, 0);
    check("rx_other_hold", rx_data, 16'h02AB);
`else
    check("rx_other_valid", rx_valid, 1);
    check("rx_other_data", rx_data, 16'h03CD);
`endif
    step(0, '0, 0, 1, 16'hFF11);
    check("rx_bcast_valid", rx_valid, 1);
    check("rx_bcast_data", rx_data, 16'hFF11);
    step(0, '0, 0, 0, '0);
    check("rx_pulse_end", rx_valid, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rd;
      logic [7:0]   dst;
      case ($urandom_range(3))
        0:       dst = DEV;
        1:       dst = BCAST;
        default: dst = 8'($urandom);
      endcase
      rd = {dst, 8'($urandom)};
      step(($urandom_range(99) < 55), 16'($urandom), ($urandom_range(99) < 45),
           ($urandom_range(1) == 1), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
